// File: rtl/uart_i2c_cmd_parser.sv
// UART command-frame parser driving an I2C master controller's request port, returning ack or read data.
// Define UART_I2C_CMD_CHECKSUM_EN to require a sixth XOR checksum byte per frame.
module uart_i2c_cmd_parser #(
    parameter int RX_TIMEOUT    = 100000,
    parameter int START_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [6:0]  i2c_device_addr,
    output logic        i2c_rw,
    output logic [7:0]  i2c_reg_addr,
    output logic [15:0] i2c_data_in,
    output logic        i2c_enable,
    input  logic        i2c_ready,
    input  logic [15:0] i2c_data_out,
    output logic        busy
);
    localparam int RX_CNT_W = $clog2(RX_TIMEOUT + 1);
    localparam int ST_CNT_W = $clog2(START_TIMEOUT + 1);
    localparam logic [RX_CNT_W-1:0] RX_LAST = RX_CNT_W'(RX_TIMEOUT - 1);
    localparam logic [ST_CNT_W-1:0] ST_LAST = ST_CNT_W'(START_TIMEOUT - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    // Frame-collection states must stay ahead of ST_ISSUE; in_frame relies on the ordering.
    typedef enum logic [3:0] {
        ST_SYNC,
        ST_DEV,
        ST_REG,
        ST_DHI,
        ST_DLO,
`ifdef UART_I2C_CMD_CHECKSUM_EN
        ST_CHK,
`endif
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [6:0]          dev_q, dev_d;
    logic                rw_q, rw_d;
    logic [7:0]          reg_q, reg_d;
    logic [15:0]         data_q, data_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          resp_lo_q, resp_lo_d;
    logic                resp_two_q, resp_two_d;
    logic [RX_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [ST_CNT_W-1:0] st_cnt_q, st_cnt_d;
`ifdef UART_I2C_CMD_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif
    logic                in_frame;

    assign in_frame = (state_q != ST_SYNC) && (state_q < ST_ISSUE);

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d    = state_q;
        dev_d      = dev_q;
        rw_d       = rw_q;
        reg_d      = reg_q;
        data_d     = data_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        resp_lo_d  = resp_lo_q;
        resp_two_d = resp_two_q;
        rx_cnt_d   = rx_cnt_q;
        st_cnt_d   = st_cnt_q;
        i2c_enable = 1'b0;
`ifdef UART_I2C_CMD_CHECKSUM_EN
        chk_d      = chk_q;
        if (in_frame && rx_valid) chk_d = chk_q ^ rx_data;
`endif

        // Inter-byte gap watchdog; a stalled partial frame is abandoned silently.
        if (in_frame) begin
            if (rx_valid)                 rx_cnt_d = '0;
            else if (rx_cnt_q == RX_LAST) state_d  = ST_SYNC;
            else                          rx_cnt_d = rx_cnt_q + RX_CNT_W'(1);
        end

        case (state_q)
            ST_SYNC: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d  = ST_DEV;
                    rx_cnt_d = '0;
`ifdef UART_I2C_CMD_CHECKSUM_EN
                    chk_d    = SYNC_BYTE;
`endif
                end
            end
            ST_DEV: if (rx_valid) begin
                dev_d   = rx_data[7:1];
                rw_d    = rx_data[0];
                state_d = ST_REG;
            end
            ST_REG: if (rx_valid) begin
                reg_d   = rx_data;
                state_d = ST_DHI;
            end
            ST_DHI: if (rx_valid) begin
                data_d  = {rx_data, data_q[7:0]};
                state_d = ST_DLO;
            end
            ST_DLO: if (rx_valid) begin
                data_d  = {data_q[15:8], rx_data};
`ifdef UART_I2C_CMD_CHECKSUM_EN
                state_d = ST_CHK;
`else
                state_d = ST_ISSUE;
`endif
            end
`ifdef UART_I2C_CMD_CHECKSUM_EN
            ST_CHK: if (rx_valid) begin
                if (rx_data == chk_q) begin
                    state_d = ST_ISSUE;
                end else begin
                    tx_data_d  = NAK_BYTE;
                    tx_valid_d = 1'b1;
                    resp_two_d = 1'b0;
                    state_d    = ST_RESP;
                end
            end
`endif
            ST_ISSUE: if (i2c_ready) begin
                i2c_enable = 1'b1;
                st_cnt_d   = '0;
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!i2c_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (st_cnt_q == ST_LAST) begin
                    tx_data_d  = NAK_BYTE;
                    tx_valid_d = 1'b1;
                    resp_two_d = 1'b0;
                    state_d    = ST_RESP;
                end else begin
                    st_cnt_d = st_cnt_q + ST_CNT_W'(1);
                end
            end
            ST_WAIT_DONE: if (i2c_ready) begin
                tx_valid_d = 1'b1;
                state_d    = ST_RESP;
                if (rw_q) begin
                    tx_data_d  = i2c_data_out[15:8];
                    resp_lo_d  = i2c_data_out[7:0];
                    resp_two_d = 1'b1;
                end else begin
                    tx_data_d  = ACK_BYTE;
                    resp_two_d = 1'b0;
                end
            end
            ST_RESP: if (tx_ready) begin
                if (resp_two_q) begin
                    tx_data_d  = resp_lo_q;
                    resp_two_d = 1'b0;
                end else begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_SYNC;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SYNC;
            dev_q      <= '0;
            rw_q       <= 1'b0;
            reg_q      <= '0;
            data_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            resp_lo_q  <= '0;
            resp_two_q <= 1'b0;
            rx_cnt_q   <= '0;
            st_cnt_q   <= '0;
`ifdef UART_I2C_CMD_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dev_q      <= dev_d;
            rw_q       <= rw_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            resp_lo_q  <= resp_lo_d;
            resp_two_q <= resp_two_d;
            rx_cnt_q   <= rx_cnt_d;
            st_cnt_q   <= st_cnt_d;
`ifdef UART_I2C_CMD_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign tx_data         = tx_data_q;
    assign tx_valid        = tx_valid_q;
    assign i2c_device_addr = dev_q;
    assign i2c_rw          = rw_q;
    assign i2c_reg_addr    = reg_q;
    assign i2c_data_in     = data_q;
    assign busy            = (state_q != ST_SYNC);
endmodule

// File: tb/tb_uart_i2c_cmd_parser.sv
// Scoreboard bench for uart_i2c_cmd_parser with a behavioural I2C controller model.
module tb_uart_i2c_cmd_parser;
    localparam int RX_TO = 300;
    localparam int ST_TO = 1024;

    typedef struct packed {
        logic [6:0]  dev;
        logic        rw;
        logic [7:0]  reg_a;
        logic [15:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [6:0]  i2c_device_addr;
    logic        i2c_rw;
    logic [7:0]  i2c_reg_addr;
    logic [15:0] i2c_data_in;
    logic        i2c_enable;
    logic        i2c_ready = 1'b1;
    logic [15:0] i2c_data_out = 16'h0000;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int n_enables = 0;
    req_t       exp_req_q[$];
    logic [7:0] exp_tx_q[$];

    bit          model_stuck = 1'b0;
    int          model_busy = 200;
    logic [15:0] model_rdata = 16'h0000;

    uart_i2c_cmd_parser #(.RX_TIMEOUT(RX_TO), .START_TIMEOUT(ST_TO)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .i2c_device_addr(i2c_device_addr), .i2c_rw(i2c_rw),
        .i2c_reg_addr(i2c_reg_addr), .i2c_data_in(i2c_data_in),
        .i2c_enable(i2c_enable), .i2c_ready(i2c_ready),
        .i2c_data_out(i2c_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Controller model: accepts a request, drops ready for model_busy cycles, then returns data.
    always begin
        @(posedge clk);
        if (rst !== 1'b1 && i2c_enable === 1'b1 && !model_stuck) begin
            #1 i2c_ready = 1'b0;
            repeat (model_busy) @(posedge clk);
            #1 i2c_data_out = model_rdata;
            i2c_ready = 1'b1;
        end
    end

    task automatic run_monitor();
        req_t r;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (i2c_enable === 1'b1) begin
                    n_enables++;
                    checks++;
                    if (exp_req_q.size() == 0) begin
                        failures++;
                        $display("FAIL i2c_req: unexpected enable dev=%h rw=%b reg=%h data=%h",
                                 i2c_device_addr, i2c_rw, i2c_reg_addr, i2c_data_in);
                    end else begin
                        r = exp_req_q.pop_front();
                        if ({i2c_device_addr, i2c_rw, i2c_reg_addr, i2c_data_in} !== r) begin
                            failures++;
                            $display("FAIL i2c_req: got dev=%h rw=%b reg=%h data=%h want dev=%h rw=%b reg=%h data=%h",
                                     i2c_device_addr, i2c_rw, i2c_reg_addr, i2c_data_in,
                                     r.dev, r.rw, r.reg_a, r.data);
                        end
                    end
                end
                if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                    checks++;
                    if (exp_tx_q.size() == 0) begin
                        failures++;
                        $display("FAIL tx_byte: unexpected byte %h", tx_data);
                    end else begin
                        b = exp_tx_q.pop_front();
                        if (tx_data !== b) begin
                            failures++;
                            $display("FAIL tx_byte: got %h want %h", tx_data, b);
                        end
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b1, b2, b3, b4,
                              input bit use_chk, input logic [7:0] chk);
        logic [7:0] x;
        x = 8'hA5 ^ b1 ^ b2 ^ b3 ^ b4;
        send_byte(8'hA5);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
`ifdef UART_I2C_CMD_CHECKSUM_EN
        send_byte(use_chk ? chk : x);
`else
        x = use_chk ? chk : x;
`endif
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && tx_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ready_cycle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i2c_ready === 1'b0) begin ok = 1'b1; break; end
        end
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (i2c_ready === 1'b1) begin ok = 1'b1; break; end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (i2c_enable !== 1'b0) begin failures++; $display("FAIL reset_enable: got %b want 0", i2c_enable); end
        checks++; if ({i2c_device_addr, i2c_rw, i2c_reg_addr, i2c_data_in} !== 32'h0) begin
            failures++; $display("FAIL reset_req: got %h want 0", {i2c_device_addr, i2c_rw, i2c_reg_addr, i2c_data_in});
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write();
        bit ok;
        model_busy = 200;
        tx_ready = 1'b1;
        exp_req_q.push_back({7'h50, 1'b0, 8'h10, 16'h1234});
        exp_tx_q.push_back(8'h06);
        send_frame(8'hA0, 8'h10, 8'h12, 8'h34, 1'b0, 8'h00);
        checks++; if (i2c_enable !== 1'b1) begin failures++; $display("FAIL write_enable_latency: got %b want 1", i2c_enable); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy: got %b want 1", busy); end
        wait_ready_cycle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL write_ctrl_cycle: got timeout want ready fall/rise"); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL write_tx_early: got %b want 0", tx_valid); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin
            failures++; $display("FAIL write_resp_latency: got v=%b d=%h want v=1 d=06", tx_valid, tx_data);
        end
        wait_idle(50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL write_idle: got busy want idle"); end
    endtask

    task automatic test_read();
        bit ok;
        model_busy = 20;
        model_rdata = 16'hBEEF;
        exp_req_q.push_back({7'h50, 1'b1, 8'h20, 16'h0000});
        exp_tx_q.push_back(8'hBE);
        exp_tx_q.push_back(8'hEF);
        send_frame(8'hA1, 8'h20, 8'h00, 8'h00, 1'b0, 8'h00);
        wait_ready_cycle(ok);
        checks++; if (!ok) begin failures++; $display("FAIL read_ctrl_cycle: got timeout want ready fall/rise"); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hBE) begin
            failures++; $display("FAIL read_hi: got v=%b d=%h want v=1 d=BE", tx_valid, tx_data);
        end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hEF) begin
            failures++; $display("FAIL read_lo_next_cycle: got v=%b d=%h want v=1 d=EF", tx_valid, tx_data);
        end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL read_done: got v=%b busy=%b want 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_noise_timeout();
        bit ok;
        int en0;
        model_busy = 10;
        send_byte(8'h00);
        send_byte(8'hFF);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL noise_dropped: got busy=%b want 0", busy); end
        send_byte(8'hA5);
        send_byte(8'hA0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL partial_busy: got busy=%b want 1", busy); end
        repeat (RX_TO + 20) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rx_timeout: got busy=%b want 0", busy); end
        en0 = n_enables;
        exp_req_q.push_back({7'h50, 1'b0, 8'h10, 16'h1234});
        exp_tx_q.push_back(8'h06);
        send_frame(8'hA0, 8'h10, 8'h12, 8'h34, 1'b0, 8'h00);
        wait_idle(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL timeout_frame_idle: got busy want idle"); end
        checks++; if (n_enables - en0 !== 1) begin
            failures++; $display("FAIL timeout_one_enable: got %0d want 1", n_enables - en0);
        end
    endtask

    task automatic test_stuck();
        bit ok;
        int cycles;
        model_stuck = 1'b1;
        exp_req_q.push_back({7'h50, 1'b0, 8'h33, 16'hABCD});
        exp_tx_q.push_back(8'h15);
        send_frame(8'hA0, 8'h33, 8'hAB, 8'hCD, 1'b0, 8'h00);
        cycles = 0;
        for (int i = 0; i < ST_TO + 50; i++) begin
            @(negedge clk);
            cycles++;
            if (tx_valid === 1'b1) break;
        end
        checks++; if (cycles < ST_TO || cycles > ST_TO + 3) begin
            failures++; $display("FAIL stuck_timeout: got %0d cycles want %0d..%0d", cycles, ST_TO, ST_TO + 3);
        end
        checks++; if (tx_data !== 8'h15) begin failures++; $display("FAIL stuck_nak: got %h want 15", tx_data); end
        wait_idle(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stuck_busy_clear: got busy want idle"); end
        model_stuck = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int unstable;
        logic [7:0] junk [5];
        junk[0] = 8'hA5; junk[1] = 8'hA0; junk[2] = 8'h10; junk[3] = 8'h12; junk[4] = 8'h34;
        model_busy = 30;
        model_rdata = 16'h1357;
        tx_ready = 1'b0;
        exp_req_q.push_back({7'h50, 1'b1, 8'h42, 16'h0000});
        exp_tx_q.push_back(8'h13);
        exp_tx_q.push_back(8'h57);
        send_frame(8'hA1, 8'h42, 8'h00, 8'h00, 1'b0, 8'h00);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL bp_resp: got no tx_valid want tx_valid"); end
        unstable = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            rx_valid = (i < 10);
            rx_data  = junk[i % 5];
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== 8'h13) unstable++;
        end
        rx_valid = 1'b0;
        checks++; if (unstable != 0) begin
            failures++; $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable);
        end
        @(posedge clk); #1 tx_ready = 1'b1;
        wait_idle(10, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_idle: got busy want idle"); end
        repeat (20) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_dropped: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        model_busy = 5;
        exp_req_q.push_back({7'h50, 1'b0, 8'h01, 16'h0001});
        exp_tx_q.push_back(8'h06);
        exp_req_q.push_back({7'h51, 1'b0, 8'h02, 16'h0002});
        exp_tx_q.push_back(8'h06);
        send_frame(8'hA0, 8'h01, 8'h00, 8'h01, 1'b0, 8'h00);
        wait_idle(100, ok);
        send_frame(8'hA2, 8'h02, 8'h00, 8'h02, 1'b0, 8'h00);
        wait_idle(100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_idle: got busy want idle"); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5);
        send_byte(8'hA0);
        send_byte(8'h10);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || i2c_enable !== 1'b0 || tx_valid !== 1'b0) begin
            failures++; $display("FAIL midreset_ctrl: got busy=%b en=%b v=%b want 0 0 0", busy, i2c_enable, tx_valid);
        end
        checks++; if (i2c_reg_addr !== 8'h00) begin
            failures++; $display("FAIL midreset_fields: got reg=%h want 00", i2c_reg_addr);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

`ifdef UART_I2C_CMD_CHECKSUM_EN
    task automatic test_checksum();
        bit ok;
        int en0;
        en0 = n_enables;
        exp_tx_q.push_back(8'h15);
        send_frame(8'hA0, 8'h10, 8'h12, 8'h34, 1'b1, 8'h00);
        wait_idle(50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL chk_idle: got busy want idle"); end
        checks++; if (n_enables !== en0) begin
            failures++; $display("FAIL chk_no_enable: got %0d pulses want 0", n_enables - en0);
        end
    endtask
`endif

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_write();
        test_read();
        test_noise_timeout();
        test_stuck();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_I2C_CMD_CHECKSUM_EN
        test_checksum();
`endif
        repeat (5) @(negedge clk);
        checks++; if (exp_req_q.size() != 0) begin
            failures++; $display("FAIL req_leftover: got %0d pending want 0", exp_req_q.size());
        end
        checks++; if (exp_tx_q.size() != 0) begin
            failures++; $display("FAIL tx_leftover: got %0d pending want 0", exp_tx_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
